mux153_scan_ctrl: RTL and testbench
===================================

# mux153_scan_ctrl

Upstream driver and self-checker for the 74153-style 4:1 selector stage. It accepts 4-bit parallel words over a valid/ready handshake and packs them onto the selector's 7-bit input bus (select, four data lines, active-low strobe). It steps the select lines through all four channels and samples the selector's output, producing a serial bit stream. It also raises a sticky error flag whenever the sampled output disagrees with the expected data bit.

## Interface
- HOLD_CYCLES, 1: cycles each select value is held before sampling; legal range 1..15.
- MSB_FIRST, 1: 1 = scan order in_data[3]..in_data[0] (sel 11,10,01,00); 0 = in_data[0]..in_data[3] (sel 00..11).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  word available.
- in_ready  out  1  word accepted on clk edge when in_valid & in_ready.
- in_data  in  4  parallel word; channel k = in_data[k].
- abort  in  1  synchronous frame kill.
- clr_err  in  1  synchronous clear of err_flag.
- mux_in  out  7  to selector input bus: [6:5] select, [4:1] = {in_data[0], in_data[1], in_data[2], in_data[3]}, [0] strobe (1 = disabled, selector output 0).
- mux_y  in  1  selector output (combinational from mux_in).
- ser_bit  out  1  serial data.
- ser_valid  out  1  ser_bit qualifier.
- frame_done  out  1  one-cycle pulse with the 4th ser_valid of a word.
- busy  out  1  high while in DRIVE.
- err_flag  out  1  sticky mismatch flag.

## Operation
- Reset values: mux_in = 7'b0000001, ser_bit 0, ser_valid 0, frame_done 0, busy 0, err_flag 0, state IDLE.
- in_ready is combinational: (IDLE or last-sample cycle) and not abort. It is never high during reset.
- mux_in is fully registered. Data lines hold the accepted word for the whole frame.
- IDLE:
  - Strobe is 1; select and data are 0.
  - On accept, the next cycle drives the first select with strobe 0, sets hold_cnt = 0, and moves to DRIVE.
- DRIVE:
  - hold_cnt counts 0..HOLD_CYCLES-1.
  - Sample cycle is hold_cnt == HOLD_CYCLES-1. On that cycle register ser_bit <= mux_y and ser_valid <= 1 (both valid the following cycle).
  - Also on the sample cycle, compare mux_y against the expected bit in_data[sel]. A mismatch sets err_flag.
  - After sampling, advance the select and reset hold_cnt.
  - After the 4th sample:
    - If a word is accepted on that same cycle, load it and drive its first select next cycle (no gap).
    - Otherwise return to IDLE: strobe 1, select 00, data 0000.
  - frame_done is registered alongside the 4th ser_valid.
- abort (highest priority) forces IDLE next cycle with mux_in = 7'b0000001.
  - ser_valid and frame_done are 0 that cycle, even if it was a sample cycle.
  - A partial frame is discarded and err_flag is unchanged.
- err_flag: set has priority over clr_err when both occur in the same cycle. The flag is only cleared by clr_err or rst.
- rst asserted mid-frame returns all outputs to reset values immediately (asynchronously). No partial output follows.

## Timing
- Accept at edge 0. The first select is driven in cycle 1.
- With HOLD_CYCLES=H, bit k (k=0..3) is sampled in cycle 1+k·H+(H-1) and appears on ser_bit/ser_valid one cycle later.
- Latency from accept to the first ser_valid is H+1 cycles.
- Frame length is 4·H cycles. Sustained throughput is 1 bit per H cycles with back-to-back words.
- ser_valid is a single-cycle pulse per bit. With H=1 and back-to-back words, ser_valid stays high continuously.
- in_ready is high for at most one cycle per frame while busy.

## Test plan
- Reset: assert rst mid-frame asynchronously → mux_in = 7'b0000001 and all other outputs 0 in the same cycle; after release, in_ready = 1.
- H=1, MSB_FIRST=1, in_data=4'b1010, behavioural 74153 model on mux_in/mux_y:
  - Cycle 1: mux_in = 7'b1101010.
  - Select sequence 11,10,01,00.
  - ser_bit = 1,0,1,0 with ser_valid in cycles 2..5.
  - frame_done in cycle 5; err_flag stays 0.
- Back-to-back: H=1, in_valid held with 4'hF then 4'h0:
  - 8 consecutive ser_valid cycles carrying 1111 then 0000.
  - in_ready high exactly once between the two words (cycle 4).
  - Strobe never returns to 1 between the two frames.
- Fault injection: mux_y stuck at 0, MSB_FIRST=1, in_data=4'b0100 → err_flag rises on the 2nd sample and stays set through IDLE; clr_err clears it; clr_err pulsed together with a new mismatch leaves it set.
- abort asserted during the 2nd bit, H=2 → next cycle mux_in = 7'b0000001, no frame_done, busy 0; a following word 4'b0011 scans correctly.
- H=3, MSB_FIRST=0, in_data=4'b0110 → select order 00,01,10,11; ser_valid every 3rd cycle with bits 0,1,1,0; first ser_valid 4 cycles after accept.

Source files
------------

// File: rtl/mux153_scan_if.sv
// Bus between the scan controller and its environment: word handshake,
// control strobes, the 74153 selector input/output pair and the serial result.
interface mux153_scan_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       abort;
  logic       clr_err;
  logic [6:0] mux_in;
  logic       mux_y;
  logic       ser_bit;
  logic       ser_valid;
  logic       frame_done;
  logic       busy;
  logic       err_flag;

  // Environment side: supplies words, controls and the selector output.
  modport master (
    output in_valid, in_data, abort, clr_err, mux_y,
    input  in_ready, mux_in, ser_bit, ser_valid, frame_done, busy, err_flag
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, abort, clr_err, mux_y,
    output in_ready, mux_in, ser_bit, ser_valid, frame_done, busy, err_flag
  );
endinterface

// File: rtl/mux153_scan_ctrl.sv
// Drives a 74153-style 4:1 selector with an accepted 4-bit word, scans all
// four channels into a serial stream and flags any output/data disagreement.
module mux153_scan_ctrl #(
  parameter int HOLD_CYCLES = 1,
  parameter int MSB_FIRST   = 1
) (
  input  logic            clk,
  input  logic            rst,
  mux153_scan_if.slave    bus
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [6:0] MUX_IDLE  = 7'b0000001;

  state_t     state_q, state_d;
  logic [6:0] mux_q, mux_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] bit_q, bit_d;
  logic       ser_bit_q, ser_bit_d;
  logic       ser_valid_q, ser_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       err_q, err_d;

  logic [3:0] word;
  logic       sample;
  logic       last_sample;
  logic       in_ready;
  logic       accept;

  function automatic logic [1:0] sel_of(input logic [1:0] k);
    return (MSB_FIRST != 0) ? ~k : k;
  endfunction

  // Selector bus for a freshly accepted word: first select, strobe enabled.
  function automatic logic [6:0] first_bus(input logic [3:0] d);
    return {sel_of(2'd0), d[0], d[1], d[2], d[3], 1'b0};
  endfunction

  // The data lines hold the word in reversed order; word[k] is channel k.
  assign word        = {mux_q[1], mux_q[2], mux_q[3], mux_q[4]};
  assign sample      = (state_q == DRIVE) && (hold_q == HOLD_LAST);
  assign last_sample = sample && (bit_q == 2'd3);
  assign in_ready    = ((state_q == IDLE) || last_sample) && !bus.abort && !rst;
  assign accept      = bus.in_valid && in_ready;

  // NOTE: every next-state variable gets its default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    mux_d        = mux_q;
    hold_d       = hold_q;
    bit_d        = bit_q;
    ser_bit_d    = ser_bit_q;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if (bus.clr_err) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          mux_d   = first_bus(bus.in_data);
          hold_d  = 4'd0;
          bit_d   = 2'd0;
        end
      end
      DRIVE: begin
        if (sample) begin
          ser_bit_d   = bus.mux_y;
          ser_valid_d = 1'b1;
          // Setting wins over a simultaneous clear.
          if (bus.mux_y != word[mux_q[6:5]]) err_d = 1'b1;
          hold_d = 4'd0;
          if (bit_q == 2'd3) begin
            frame_done_d = 1'b1;
            bit_d        = 2'd0;
            if (accept) begin
              mux_d = first_bus(bus.in_data);
            end else begin
              state_d = IDLE;
              mux_d   = MUX_IDLE;
            end
          end else begin
            bit_d       = bit_q + 2'd1;
            mux_d[6:5]  = sel_of(bit_q + 2'd1);
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the partial frame and suppresses its sample outputs.
    if (bus.abort) begin
      state_d      = IDLE;
      mux_d        = MUX_IDLE;
      hold_d       = 4'd0;
      bit_d        = 2'd0;
      ser_bit_d    = ser_bit_q;
      ser_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q && !bus.clr_err;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mux_q        <= MUX_IDLE;
      hold_q       <= 4'd0;
      bit_q        <= 2'd0;
      ser_bit_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mux_q        <= mux_d;
      hold_q       <= hold_d;
      bit_q        <= bit_d;
      ser_bit_q    <= ser_bit_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.mux_in     = mux_q;
  assign bus.ser_bit    = ser_bit_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == DRIVE);
  assign bus.err_flag   = err_q;

endmodule

// File: tb/tb_mux153_scan_ctrl.sv
// Directed bench: three controller instances (H=1/MSB, H=2/MSB, H=3/LSB)
// each closed through a behavioural 74153 model.
module tb_mux153_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck_a = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux153_scan_if if_a ();
  mux153_scan_if if_b ();
  mux153_scan_if if_c ();

  mux153_scan_ctrl #(.HOLD_CYCLES(1), .MSB_FIRST(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  mux153_scan_ctrl #(.HOLD_CYCLES(2), .MSB_FIRST(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  mux153_scan_ctrl #(.HOLD_CYCLES(3), .MSB_FIRST(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  // 74153 section: strobe high forces 0, otherwise route the selected line.
  function automatic logic sel153(input logic [6:0] m);
    logic [3:0] w;
    w = {m[1], m[2], m[3], m[4]};
    return m[0] ? 1'b0 : w[m[6:5]];
  endfunction

  assign if_a.mux_y = stuck_a ? 1'b0 : sel153(if_a.mux_in);
  assign if_b.mux_y = sel153(if_b.mux_in);
  assign if_c.mux_y = sel153(if_c.mux_in);

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [6:0] mux;
    logic       rdy;
    logic       sv;
    logic       sb;
    logic       fd;
    logic       busy;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive the chosen instance just after the edge, return
  // at the falling edge where outputs are sampled.
  task automatic cyc(input int which, input logic v, input logic [3:0] d,
                     input logic ab, input logic cl);
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0; if_a.in_data = 4'h0; if_a.abort = 1'b0; if_a.clr_err = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = 4'h0; if_b.abort = 1'b0; if_b.clr_err = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = 4'h0; if_c.abort = 1'b0; if_c.clr_err = 1'b0;
    case (which)
      0: begin if_a.in_valid = v; if_a.in_data = d; if_a.abort = ab; if_a.clr_err = cl; end
      1: begin if_b.in_valid = v; if_b.in_data = d; if_b.abort = ab; if_b.clr_err = cl; end
      default: begin if_c.in_valid = v; if_c.in_data = d; if_c.abort = ab; if_c.clr_err = cl; end
    endcase
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single frame 1010 (cycles 0..5), then back-to-back F,0 (cycles 6..16).
    tbl[0]  = '{1'b1, 4'b1010, 7'b0000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 7'b1101010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'b0000, 7'b1001010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'b0000, 7'b0101010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 7'b0001010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 7'b0000001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b1111, 7'b0000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0000, 7'b1111110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'b0000, 7'b1011110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'b0000, 7'b0111110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 4'b0000, 7'b0011110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'b0000, 7'b1100000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 7'b1000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 7'b0100000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 4'b0000, 7'b0000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 7'b0000001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 7'b0000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    if_a.in_valid = 1'b0; if_a.in_data = 4'h0; if_a.abort = 1'b0; if_a.clr_err = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = 4'h0; if_b.abort = 1'b0; if_b.clr_err = 1'b0;
    if_c.in_valid = 1'b0; if_c.in_data = 4'h0; if_c.abort = 1'b0; if_c.clr_err = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mux_in", 32'(if_a.mux_in), 32'h01);
    check("reset_ready", 32'(if_a.in_ready), 32'h0);
    check("reset_err", 32'(if_a.err_flag), 32'h0);
    rst = 1'b0;

    // ---- Table: H=1, MSB first ----
    for (int i = 0; i < 17; i++) begin
      cyc(0, tbl[i].v, tbl[i].d, 1'b0, 1'b0);
      check($sformatf("tbl[%0d].mux_in", i), 32'(if_a.mux_in), 32'(tbl[i].mux));
      check($sformatf("tbl[%0d].in_ready", i), 32'(if_a.in_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl[%0d].ser_valid", i), 32'(if_a.ser_valid), 32'(tbl[i].sv));
      check($sformatf("tbl[%0d].ser_bit", i), 32'(if_a.ser_bit), 32'(tbl[i].sb));
      check($sformatf("tbl[%0d].frame_done", i), 32'(if_a.frame_done), 32'(tbl[i].fd));
      check($sformatf("tbl[%0d].busy", i), 32'(if_a.busy), 32'(tbl[i].busy));
      check($sformatf("tbl[%0d].err", i), 32'(if_a.err_flag), 32'h0);
    end

    // ---- Fault injection: mux_y stuck at 0, word 0100 ----
    stuck_a = 1'b1;
    cyc(0, 1'b1, 4'b0100, 1'b0, 1'b0);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);                     // 1st sample, matches
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);                     // 2nd sample, mismatch
    check("fault_err_before", 32'(if_a.err_flag), 32'h0);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("fault_err_rise", 32'(if_a.err_flag), 32'h1);
    repeat (3) cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("fault_idle_busy", 32'(if_a.busy), 32'h0);
    check("fault_err_sticky", 32'(if_a.err_flag), 32'h1);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b1);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("fault_err_cleared", 32'(if_a.err_flag), 32'h0);
    cyc(0, 1'b1, 4'b0100, 1'b0, 1'b0);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b1);                     // clear with mismatch
    check("fault_err_pre_collide", 32'(if_a.err_flag), 32'h0);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("fault_set_beats_clear", 32'(if_a.err_flag), 32'h1);
    repeat (3) cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    stuck_a = 1'b0;

    // ---- Abort during 2nd bit, H=2, then word 0011 ----
    cyc(1, 1'b1, 4'b1100, 1'b0, 1'b0);
    check("abort_c0_ready", 32'(if_b.in_ready), 32'h1);
    cyc(1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("abort_c1_mux", 32'(if_b.mux_in), 32'b1100110);
    cyc(1, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1, 1'b0, 4'h0, 1'b0, 1'b0);
    check("abort_c3_sv", 32'(if_b.ser_valid), 32'h1);
    check("abort_c3_sb", 32'(if_b.ser_bit), 32'h1);
    check("abort_c3_mux", 32'(if_b.mux_in), 32'b1000110);
    cyc(1, 1'b0, 4'h0, 1'b1, 1'b0);
    check("abort_c4_ready", 32'(if_b.in_ready), 32'h0);
    cyc(1, 1'b1, 4'b0011, 1'b0, 1'b0);
    check("abort_c5_mux", 32'(if_b.mux_in), 32'h01);
    check("abort_c5_sv", 32'(if_b.ser_valid), 32'h0);
    check("abort_c5_fd", 32'(if_b.frame_done), 32'h0);
    check("abort_c5_busy", 32'(if_b.busy), 32'h0);
    check("abort_c5_ready", 32'(if_b.in_ready), 32'h1);
    for (int k = 6; k <= 15; k++) begin
      logic       e_sv;
      logic       e_sb;
      cyc(1, 1'b0, 4'h0, 1'b0, 1'b0);
      e_sv = (k == 8) || (k == 10) || (k == 12) || (k == 14);
      e_sb = (k == 12) || (k == 14);
      check($sformatf("after_abort[%0d].sv", k), 32'(if_b.ser_valid), 32'(e_sv));
      if (e_sv) check($sformatf("after_abort[%0d].sb", k), 32'(if_b.ser_bit), 32'(e_sb));
      check($sformatf("after_abort[%0d].fd", k), 32'(if_b.frame_done), 32'(k == 14));
      case (k)
        6:  check("after_abort[6].mux", 32'(if_b.mux_in), 32'b1111000);
        8:  check("after_abort[8].mux", 32'(if_b.mux_in), 32'b1011000);
        10: check("after_abort[10].mux", 32'(if_b.mux_in), 32'b0111000);
        12: check("after_abort[12].mux", 32'(if_b.mux_in), 32'b0011000);
        14: check("after_abort[14].mux", 32'(if_b.mux_in), 32'b0000001);
        default: ;
      endcase
    end
    check("abort_err", 32'(if_b.err_flag), 32'h0);

    // ---- H=3, LSB first, word 0110 ----
    cyc(2, 1'b1, 4'b0110, 1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      logic e_sv;
      cyc(2, 1'b0, 4'h0, 1'b0, 1'b0);
      e_sv = (k == 4) || (k == 7) || (k == 10) || (k == 13);
      check($sformatf("h3[%0d].sv", k), 32'(if_c.ser_valid), 32'(e_sv));
      check($sformatf("h3[%0d].fd", k), 32'(if_c.frame_done), 32'(k == 13));
      if (e_sv) check($sformatf("h3[%0d].sb", k), 32'(if_c.ser_bit), 32'((k == 7) || (k == 10)));
      case (k)
        1:  check("h3[1].mux", 32'(if_c.mux_in), 32'b0001100);
        4:  check("h3[4].mux", 32'(if_c.mux_in), 32'b0101100);
        7:  check("h3[7].mux", 32'(if_c.mux_in), 32'b1001100);
        10: check("h3[10].mux", 32'(if_c.mux_in), 32'b1101100);
        13: check("h3[13].mux", 32'(if_c.mux_in), 32'b0000001);
        default: ;
      endcase
    end
    check("h3_err", 32'(if_c.err_flag), 32'h0);

    // ---- Asynchronous reset mid-frame (err_flag still set from above) ----
    cyc(0, 1'b1, 4'b1111, 1'b0, 1'b0);
    repeat (3) cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("pre_rst_sv", 32'(if_a.ser_valid), 32'h1);
    check("pre_rst_err", 32'(if_a.err_flag), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mux", 32'(if_a.mux_in), 32'h01);
    check("async_rst_sv", 32'(if_a.ser_valid), 32'h0);
    check("async_rst_sb", 32'(if_a.ser_bit), 32'h0);
    check("async_rst_fd", 32'(if_a.frame_done), 32'h0);
    check("async_rst_busy", 32'(if_a.busy), 32'h0);
    check("async_rst_err", 32'(if_a.err_flag), 32'h0);
    check("async_rst_ready", 32'(if_a.in_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(if_a.in_ready), 32'h1);
    cyc(0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("post_rst_sv", 32'(if_a.ser_valid), 32'h0);
    check("post_rst_mux", 32'(if_a.mux_in), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
